vote_sequencer: RTL

VOTE_SEQUENCER -- requirements
Module: vote_sequencer

---
 rtl/vote_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vote_sequencer.sv
`timescale 1ns/1ps
// Purpose: collects one vote from each of four voters per round and issues a 3-of-4 majority decision.
// Latency: decision pulses one cycle after the last vote arrives, or after TIMEOUT collect cycles.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy.
module vote_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] valid_in,
    input  logic [3:0] vote_in,
    output logic       busy,
    output logic       result_valid,
    output logic       result,
    output logic [3:0] missing,
    output logic [7:0] round_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2
    } state_t;

    // Counter value of the final collect cycle; the window closes at that edge.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;

    logic [3:0] votes;
    logic [3:0] got;
    logic [7:0] win_cnt;

    logic [3:0] capture;
    logic [3:0] got_nxt;
    logic [3:0] votes_nxt;
    logic       all_in;
    logic       window_end;
    logic       collect_done;
    logic       decision;

    // Capture view of this cycle: a voter is taken only on its first valid of the round.
    always_comb begin
        capture      = valid_in & ~got;
        got_nxt      = got | capture;
        votes_nxt    = (votes & ~capture) | (vote_in & capture);
        all_in       = (got_nxt == 4'b1111);
        window_end   = (win_cnt == LAST_CNT);
        collect_done = all_in || window_end;
        // Votes never received are forced to 0 so silence cannot count as a yes.
        decision     = ($countones(votes_nxt & got_nxt) >= 3);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; completion and timeout share a single exit.
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                busy = 1'b1;
                if (collect_done) begin
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-round vote latches and window counter; cleared when a round is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            votes   <= 4'b0000;
            got     <= 4'b0000;
            win_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        votes   <= 4'b0000;
                        got     <= 4'b0000;
                        win_cnt <= 8'd0;
                    end
                end
                COLLECT: begin
                    votes   <= votes_nxt;
                    got     <= got_nxt;
                    win_cnt <= win_cnt + 8'd1;
                end
                default: begin
                    votes   <= votes;
                    got     <= got;
                    win_cnt <= win_cnt;
                end
            endcase
        end
    end

    // Round outcome registers; loaded on the edge into DECIDE and held until the next round ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= 1'b0;
            missing   <= 4'b0000;
            round_cnt <= 8'd0;
        end else if (state == COLLECT && collect_done) begin
            result    <= decision;
            missing   <= ~got_nxt;
            round_cnt <= round_cnt + 8'd1;
        end
    end

endmodule
